// File: rtl/mux_rr_stream_if.sv
// Stream bundle for mux_rr_stream: N valid/ready input channels, one output channel.
// slave  : seen from the multiplexer (consumes inputs, produces the output beat).
// master : seen from the environment (drives inputs, consumes the output beat).
interface mux_rr_stream_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) ();
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_sel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_rr_stream.sv
// N-channel registered stream multiplexer with round-robin or fixed-priority arbitration.
// A single output register holds the granted beat; a new beat may be loaded whenever
// the register is empty or is being drained in the same cycle, so throughput is one
// beat per cycle with no bubble on drain-and-refill.
module mux_rr_stream #(
  parameter int WIDTH      = 16,
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  mux_rr_stream_if.slave  bus
);

  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_load;
  logic             w_any;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_gidx;
  logic [SELW-1:0]  w_start;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_gdata;

  // Output register can take a beat when empty or when its beat leaves this cycle.
  assign w_load = ~r_valid | bus.out_ready;

  // Fixed priority always scans from channel 0; round-robin scans from the pointer.
  assign w_start = (FIXED_PRIO != 0) ? {SELW{1'b0}} : r_ptr;

  // Pointer moves one past the granted channel, wrapping after the last one.
  assign w_ptr_nxt = (w_gidx == SELW'(N - 1)) ? {SELW{1'b0}} : (w_gidx + SELW'(1));

  // Circular scan from w_start: first valid channel wins, producing a one-hot grant.
  always_comb begin : p_grant
    int v_idx;
    w_grant = {N{1'b0}};
    w_any   = 1'b0;
    w_gidx  = {SELW{1'b0}};
    w_gdata = {WIDTH{1'b0}};
    v_idx   = 0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(w_start) + k;
      if (v_idx >= N) begin
        v_idx = v_idx - N;
      end else begin
        v_idx = v_idx;
      end
      if (!w_any && bus.in_valid[v_idx]) begin
        w_any          = 1'b1;
        w_grant[v_idx] = 1'b1;
        w_gidx         = SELW'(v_idx);
        w_gdata        = bus.in_data[v_idx*WIDTH +: WIDTH];
      end else begin
        w_any = w_any;
      end
    end
  end

  // Accept only when the output register can load; nothing is accepted during reset.
  assign bus.in_ready  = {N{w_load & ~rst}} & w_grant;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_sel   = r_sel;

  // Output register and arbitration pointer: load granted beat, empty on idle, hold when stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
      r_sel   <= {SELW{1'b0}};
      r_ptr   <= {SELW{1'b0}};
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_gdata;
        r_sel   <= w_gidx;
        if (FIXED_PRIO == 0) begin
          r_ptr <= w_ptr_nxt;
        end else begin
          r_ptr <= {SELW{1'b0}};
        end
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream: a round-robin and a fixed-priority instance
// receive identical stimulus; each is compared every cycle against a queue-free
// behavioural model (circular search with modulo arithmetic), plus directed checks.
module tb_mux_rr_stream;

  localparam int W  = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_stream_if #(.WIDTH(W), .N(NC)) bus_rr ();
  mux_rr_stream_if #(.WIDTH(W), .N(NC)) bus_fp ();

  mux_rr_stream #(.WIDTH(W), .N(NC), .FIXED_PRIO(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  mux_rr_stream #(.WIDTH(W), .N(NC), .FIXED_PRIO(1)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // current stimulus
  logic [NC-1:0]   cur_v;
  logic [NC*W-1:0] cur_d;
  logic            cur_rdy;

  // reference model state, index 0 = round-robin, 1 = fixed priority
  int          m_ptr   [2];
  logic        m_valid [2];
  logic [W-1:0] m_data [2];
  int          m_sel   [2];

  localparam logic [NC*W-1:0] DATA_A = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic [NC*W-1:0] d, input logic rdy);
    cur_v   = v;
    cur_d   = d;
    cur_rdy = rdy;
    bus_rr.in_valid  = v;
    bus_rr.in_data   = d;
    bus_rr.out_ready = rdy;
    bus_fp.in_valid  = v;
    bus_fp.in_data   = d;
    bus_fp.out_ready = rdy;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]   = 0;
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_sel[d]   = 0;
    end
  endtask

  // Channel granted this cycle by the reference rules, or -1 for none.
  function automatic int ref_grant(input int d);
    int start;
    int c;
    if (m_valid[d] && !cur_rdy) return -1;
    start = (d == 1) ? 0 : m_ptr[d];
    for (int k = 0; k < NC; k++) begin
      c = (start + k) % NC;
      if (cur_v[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_dut(input int d, input logic [NC-1:0] rdy, input logic ov,
                           input logic [W-1:0] od, input logic [1:0] os);
    int g;
    logic [NC-1:0] exp_rdy;
    string pfx;
    pfx = (d == 0) ? "rr" : "fp";
    g = ref_grant(d);
    exp_rdy = (g >= 0) ? (NC'(1) << g) : '0;
    chk({pfx, ".in_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({pfx, ".out_valid"}, 32'(ov), 32'(m_valid[d]));
    chk({pfx, ".out_data"}, 32'(od), 32'(m_data[d]));
    chk({pfx, ".out_sel"}, 32'(os), 32'(m_sel[d]));
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int g [2];
    @(negedge clk);
    check_dut(0, bus_rr.in_ready, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
    check_dut(1, bus_fp.in_ready, bus_fp.out_valid, bus_fp.out_data, bus_fp.out_sel);
    for (int d = 0; d < 2; d++) g[d] = ref_grant(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!m_valid[d] || cur_rdy) begin
        if (g[d] >= 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = cur_d[g[d]*W +: W];
          m_sel[d]   = g[d];
          if (d == 0) m_ptr[d] = (g[d] + 1) % NC;
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
    #1;
  endtask

  int exp_seq [4];

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset.out_valid", 32'(bus_rr.out_valid), 32'd0);
    chk("reset.in_ready", 32'(bus_rr.in_ready), 32'd0);
    rst = 1'b0;

    // Round-robin with every channel valid: 0,1,2,3,0; fixed priority stays on 0.
    drive(4'b1111, DATA_A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_all.sel", 32'(bus_rr.out_sel), 32'(i % NC));
      chk("rr_all.data", 32'(bus_rr.out_data), 32'(16'hA000 + 16'(i % NC)));
      chk("fp_all.sel", 32'(bus_fp.out_sel), 32'd0);
    end

    // Backpressure: output held for 3 cycles, then next beat without a gap.
    drive(4'b1111, DATA_A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp.valid", 32'(bus_rr.out_valid), 32'd1);
      chk("bp.sel", 32'(bus_rr.out_sel), 32'd0);
      chk("bp.data", 32'(bus_rr.out_data), 32'hA000);
    end
    drive(4'b1111, DATA_A, 1'b1);
    cycle();
    chk("bp_rel.valid", 32'(bus_rr.out_valid), 32'd1);
    chk("bp_rel.sel", 32'(bus_rr.out_sel), 32'd1);

    // Sparse round-robin: grant ch1 alone (pointer -> 2), then ch1+ch3 -> 3,1,3,1.
    drive(4'b0010, DATA_A, 1'b1);
    cycle();
    exp_seq = '{3, 1, 3, 1};
    drive(4'b1010, DATA_A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("sparse.sel", 32'(bus_rr.out_sel), 32'(exp_seq[i]));
    end

    // Fixed priority: ch0 and ch2 valid -> ch0 always; dropping ch0 gives ch2.
    drive(4'b0101, DATA_A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fixed.sel", 32'(bus_fp.out_sel), 32'd0);
    end
    drive(4'b0100, DATA_A, 1'b1);
    cycle();
    chk("fixed_drop.sel", 32'(bus_fp.out_sel), 32'd2);

    // Idle: output empties, data and channel index hold.
    drive(4'b0000, DATA_A, 1'b1);
    cycle();
    chk("idle.valid", 32'(bus_rr.out_valid), 32'd0);
    chk("idle.rr_sel", 32'(bus_rr.out_sel), 32'd2);
    chk("idle.rr_data", 32'(bus_rr.out_data), 32'hA002);
    chk("idle.fp_sel", 32'(bus_fp.out_sel), 32'd2);
    chk("idle.fp_data", 32'(bus_fp.out_data), 32'hA002);

    // Reset mid-beat: clears immediately; first grant afterwards is channel 0.
    drive(4'b1111, DATA_A, 1'b0);
    cycle();
    chk("pre_rst.valid", 32'(bus_rr.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst.valid", 32'(bus_rr.out_valid), 32'd0);
    chk("rst.data", 32'(bus_rr.out_data), 32'd0);
    chk("rst.sel", 32'(bus_rr.out_sel), 32'd0);
    chk("rst.in_ready", 32'(bus_rr.in_ready), 32'd0);
    chk("rst.fp_valid", 32'(bus_fp.out_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    drive(4'b1111, DATA_A, 1'b1);
    cycle();
    chk("post_rst.sel", 32'(bus_rr.out_sel), 32'd0);
    chk("post_rst.data", 32'(bus_rr.out_data), 32'hA000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(NC'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
